// File: rtl/spi_master_if.sv
// ============================================================================
// Module : spi_master_if
// Brief  : Handshake and serial pin bundle between an SPI master and its user.
// Rev    : 1.0
// ============================================================================
`default_nettype none

interface spi_master_if #(
    parameter int DATA_W = 32
) ();
    logic              start;
    logic [DATA_W-1:0] tx_data;
    logic              ready;
    logic              done;
    logic [DATA_W-1:0] rx_data;
    logic              sclk;
    logic              ss;
    logic              mosi;
    logic              miso;

    modport master (
        input  start, tx_data, miso,
        output ready, done, rx_data, sclk, ss, mosi
    );

    modport slave (
        output start, tx_data, miso,
        input  ready, done, rx_data, sclk, ss, mosi
    );
endinterface

`default_nettype wire

// File: rtl/spi_master.sv
// ============================================================================
// Module : spi_master
// Brief  : SPI mode-0 master, one DATA_W word per frame, MSB first.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module spi_master #(
    parameter int DATA_W  = 32,
    parameter int CLK_DIV = 4
) (
    input  logic              clk,
    input  logic              rst,
    spi_master_if.master      bus
);

    localparam int c_DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int c_BIT_W = $clog2(DATA_W);
    localparam logic [c_DIV_W-1:0] c_DIV_LOAD = c_DIV_W'(CLK_DIV - 1);
    localparam logic [c_BIT_W-1:0] c_BIT_LOAD = c_BIT_W'(DATA_W - 1);

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_LEAD = 3'd1,
        ST_HIGH = 3'd2,
        ST_LOW  = 3'd3,
        ST_GAP  = 3'd4
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [c_DIV_W-1:0]  r_div;
    logic [c_DIV_W-1:0]  w_div_nxt;
    logic [c_BIT_W-1:0]  r_bit;
    logic [c_BIT_W-1:0]  w_bit_nxt;
    logic [DATA_W-1:0]   r_tx;
    logic [DATA_W-1:0]   w_tx_nxt;
    logic [DATA_W-1:0]   r_rx;
    logic [DATA_W-1:0]   w_rx_nxt;
    logic [DATA_W-1:0]   r_rx_data;
    logic [DATA_W-1:0]   w_rx_data_nxt;
    logic                r_ready;
    logic                w_ready_nxt;
    logic                r_done;
    logic                w_done_nxt;
    logic                r_sclk;
    logic                w_sclk_nxt;
    logic                r_ss;
    logic                w_ss_nxt;
    logic                r_mosi;
    logic                w_mosi_nxt;
    logic                w_div_zero;

    assign w_div_zero = (r_div == '0);

    always_comb begin
        w_state_nxt   = r_state;
        w_div_nxt     = r_div;
        w_bit_nxt     = r_bit;
        w_tx_nxt      = r_tx;
        w_rx_nxt      = r_rx;
        w_rx_data_nxt = r_rx_data;
        w_done_nxt    = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (bus.start) begin
                    w_state_nxt = ST_LEAD;
                    w_tx_nxt    = bus.tx_data;
                    w_rx_nxt    = '0;
                    w_div_nxt   = c_DIV_LOAD;
                    w_bit_nxt   = c_BIT_LOAD;
                end
            end
            ST_LEAD: begin
                if (w_div_zero) begin
                    w_state_nxt = ST_HIGH;
                    w_div_nxt   = c_DIV_LOAD;
                    w_rx_nxt    = {r_rx[DATA_W-2:0], bus.miso};
                end else begin
                    w_div_nxt   = r_div - 1'b1;
                end
            end
            ST_HIGH: begin
                if (w_div_zero) begin
                    w_state_nxt = ST_LOW;
                    w_div_nxt   = c_DIV_LOAD;
                    w_tx_nxt    = {r_tx[DATA_W-2:0], 1'b0};
                end else begin
                    w_div_nxt   = r_div - 1'b1;
                end
            end
            ST_LOW: begin
                if (w_div_zero) begin
                    w_div_nxt = c_DIV_LOAD;
                    if (r_bit != '0) begin
                        w_state_nxt = ST_HIGH;
                        w_bit_nxt   = r_bit - 1'b1;
                        w_rx_nxt    = {r_rx[DATA_W-2:0], bus.miso};
                    end else begin
                        // Last bit already captured on the final HIGH entry.
                        w_state_nxt   = ST_GAP;
                        w_done_nxt    = 1'b1;
                        w_rx_data_nxt = r_rx;
                    end
                end else begin
                    w_div_nxt = r_div - 1'b1;
                end
            end
            ST_GAP: begin
                if (w_div_zero) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_div_nxt   = r_div - 1'b1;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase

        // Outputs are decoded from the next state so they leave a register.
        w_ready_nxt = (w_state_nxt == ST_IDLE);
        w_ss_nxt    = (w_state_nxt == ST_IDLE) || (w_state_nxt == ST_GAP);
        w_sclk_nxt  = (w_state_nxt == ST_HIGH);
        w_mosi_nxt  = ((w_state_nxt == ST_LEAD) || (w_state_nxt == ST_HIGH) ||
                       (w_state_nxt == ST_LOW)) ? w_tx_nxt[DATA_W-1] : 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_div     <= '0;
            r_bit     <= '0;
            r_tx      <= '0;
            r_rx      <= '0;
            r_rx_data <= '0;
            r_ready   <= 1'b1;
            r_done    <= 1'b0;
            r_sclk    <= 1'b0;
            r_ss      <= 1'b1;
            r_mosi    <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_div     <= w_div_nxt;
            r_bit     <= w_bit_nxt;
            r_tx      <= w_tx_nxt;
            r_rx      <= w_rx_nxt;
            r_rx_data <= w_rx_data_nxt;
            r_ready   <= w_ready_nxt;
            r_done    <= w_done_nxt;
            r_sclk    <= w_sclk_nxt;
            r_ss      <= w_ss_nxt;
            r_mosi    <= w_mosi_nxt;
        end
    end

    assign bus.ready   = r_ready;
    assign bus.done    = r_done;
    assign bus.rx_data = r_rx_data;
    assign bus.sclk    = r_sclk;
    assign bus.ss      = r_ss;
    assign bus.mosi    = r_mosi;

endmodule

`default_nettype wire

// File: tb/tb_spi_master.sv
// ============================================================================
// Module : tb_spi_master
// Brief  : Self-checking bench for spi_master (8-bit/div-2 and 32-bit/div-1).
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_spi_master;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    spi_master_if #(.DATA_W(8))  bus8  ();
    spi_master_if #(.DATA_W(32)) bus32 ();

    spi_master #(.DATA_W(8),  .CLK_DIV(2)) u_dut8  (.clk(clk), .rst(rst), .bus(bus8));
    spi_master #(.DATA_W(32), .CLK_DIV(1)) u_dut32 (.clk(clk), .rst(rst), .bus(bus32));

    int          n_tests = 0;
    int          n_fail  = 0;
    int          cyc     = 0;
    logic        sel     = 1'b0;
    int          dw      = 8;
    int          cd      = 2;
    logic        lb      = 1'b1;
    logic [31:0] slv     = '0;
    logic        slv_bit = 1'b0;
    int          sidx    = 0;
    logic        slv_ps  = 1'b0;
    logic [31:0] prev_rx [2];
    int          t_acc   = 0;
    int          t_done  = 0;

    logic        m_ss, m_sclk, m_mosi, m_done, m_ready;
    logic [31:0] m_rx;
    assign m_ss    = sel ? bus32.ss    : bus8.ss;
    assign m_sclk  = sel ? bus32.sclk  : bus8.sclk;
    assign m_mosi  = sel ? bus32.mosi  : bus8.mosi;
    assign m_done  = sel ? bus32.done  : bus8.done;
    assign m_ready = sel ? bus32.ready : bus8.ready;
    assign m_rx    = sel ? bus32.rx_data : {24'h0, bus8.rx_data};

    assign bus8.miso  = lb ? bus8.mosi  : slv_bit;
    assign bus32.miso = lb ? bus32.mosi : slv_bit;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic set_sel(input logic s);
        sel = s;
        dw  = s ? 32 : 8;
        cd  = s ? 1 : 2;
    endtask

    task automatic drive(input logic st, input logic [31:0] d);
        if (sel) begin
            bus32.start = st; bus32.tx_data = d;
        end else begin
            bus8.start = st;  bus8.tx_data = d[7:0];
        end
    endtask

    // Advance one clock; outputs are sampled 1ns after the edge. The slave
    // model presents the MSB on select and moves on at each falling sclk.
    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        if (m_ss) sidx = 0;
        else if (slv_ps && !m_sclk) sidx++;
        slv_ps  = m_sclk;
        slv_bit = (sidx < dw) ? slv[dw-1-sidx] : 1'b0;
    endtask

    task automatic run_frame(input logic [31:0] tx, input logic [31:0] sw, input logic loop_en,
                             input int junk_n, input logic keep, input logic [31:0] tx_after);
        int          budget, rises, bad_rise, ss_low, dones, done_at, t_rdy, last, len_ss;
        logic        ps;
        logic [31:0] mword, rx_at_done, mask, exp_rx;
        len_ss = cd * (2 * dw + 1);
        last   = cd * (2 * dw + 2);
        mask   = (dw == 32) ? 32'hFFFF_FFFF : ((32'h1 << dw) - 32'h1);
        exp_rx = (loop_en ? tx : sw) & mask;
        lb = loop_en; slv = sw;
        drive(1'b1, tx);
        budget = 0;
        while (!m_ready && budget < 1000) begin tick(); budget++; end
        check_eq("accept_wait", 32'(budget < 1000), 32'd1);
        tick();
        t_acc = cyc;
        drive(keep, tx_after);
        check_eq("rx_hold", m_rx, prev_rx[sel]);
        rises = 0; bad_rise = 0; ss_low = 0; dones = 0; done_at = -1; t_rdy = -1;
        ps = 1'b0; mword = '0; rx_at_done = '0;
        for (int n = 0; n <= last; n++) begin
            if (!m_ss) ss_low++;
            if (m_sclk && !ps) begin
                rises++;
                if (n != cd * (2 * rises - 1)) bad_rise++;
                mword = {mword[30:0], m_mosi};
            end
            ps = m_sclk;
            if (m_done) begin dones++; done_at = n; rx_at_done = m_rx; end
            if (m_ready && t_rdy < 0) t_rdy = n;
            if (n == junk_n)     drive(1'b1, 32'h0);
            if (n == junk_n + 1) drive(1'b0, tx_after);
            if (n < last) tick();
        end
        t_done = t_acc + done_at;
        prev_rx[sel] = exp_rx;
        check_eq("sclk_rises",  32'(rises), 32'(dw));
        check_eq("rise_timing", 32'(bad_rise), 32'd0);
        check_eq("mosi_bits",   mword, tx & mask);
        check_eq("ss_low_len",  32'(ss_low), 32'(len_ss));
        check_eq("done_count",  32'(dones), 32'd1);
        check_eq("done_cycle",  32'(done_at), 32'(len_ss));
        check_eq("rx_data",     rx_at_done, exp_rx);
        check_eq("ready_cycle", 32'(t_rdy), 32'(last));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int t_acc1, t_done1, r, b, dn;
        logic ps;
        logic [31:0] tx, sw, ta;
        bus8.start = 1'b0;  bus8.tx_data = '0;
        bus32.start = 1'b0; bus32.tx_data = '0;
        prev_rx[0] = '0; prev_rx[1] = '0;
        rst = 1'b1;
        repeat (3) tick();
        for (int s = 0; s < 2; s++) begin
            set_sel(s[0]);
            check_eq("rst_ready", 32'(m_ready), 32'd1);
            check_eq("rst_done",  32'(m_done),  32'd0);
            check_eq("rst_rx",    m_rx,         32'd0);
            check_eq("rst_ss",    32'(m_ss),    32'd1);
            check_eq("rst_sclk",  32'(m_sclk),  32'd0);
            check_eq("rst_mosi",  32'(m_mosi),  32'd0);
        end
        // Reset wins over a simultaneous start.
        set_sel(1'b0);
        drive(1'b1, 32'hA5);
        tick();
        check_eq("rst_prio_ss", 32'(m_ss), 32'd1);
        drive(1'b0, 32'h0);
        rst = 1'b0;
        tick();

        run_frame(32'hA5, 32'h0, 1'b1, -1, 1'b0, 32'h0);       // basic loopback
        run_frame(32'hFF, 32'h3C, 1'b0, -1, 1'b0, 32'h0);      // independent miso
        run_frame(32'h81, 32'h0, 1'b1, 10, 1'b0, 32'h0);       // ignored start
        repeat (40) tick();
        check_eq("no_extra_frame", 32'(m_ss), 32'd1);

        // Back-to-back with start held.
        run_frame(32'h12, 32'h0, 1'b1, -1, 1'b1, 32'h34);
        t_acc1 = t_acc; t_done1 = t_done;
        run_frame(32'h34, 32'h0, 1'b1, -1, 1'b0, 32'h0);
        check_eq("b2b_ss_gap",  32'(t_acc - t_done1), 32'(cd + 1));
        check_eq("b2b_period",  32'(t_acc - t_acc1), 32'(cd * (2 * dw + 2) + 1));

        // Reset after the 4th sclk rise.
        lb = 1'b1;
        drive(1'b1, 32'hC3);
        b = 0;
        while (!m_ready && b < 100) begin tick(); b++; end
        tick();
        drive(1'b0, 32'h0);
        r = 0; ps = 1'b0; b = 0;
        while (r < 4 && b < 200) begin
            tick(); b++;
            if (m_sclk && !ps) r++;
            ps = m_sclk;
        end
        check_eq("rst_mid_reach4", 32'(r), 32'd4);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_eq("rst_mid_ss",    32'(m_ss),    32'd1);
        check_eq("rst_mid_sclk",  32'(m_sclk),  32'd0);
        check_eq("rst_mid_ready", 32'(m_ready), 32'd1);
        check_eq("rst_mid_rx",    m_rx,         32'd0);
        dn = 32'(m_done);
        for (int i = 0; i < 60; i++) begin tick(); dn += 32'(m_done); end
        check_eq("rst_mid_nodone", 32'(dn), 32'd0);
        prev_rx[0] = '0; prev_rx[1] = '0;
        run_frame(32'h5A, 32'h0, 1'b1, -1, 1'b0, 32'h0);

        set_sel(1'b1);
        run_frame(32'hDEADBEEF, 32'h0, 1'b1, -1, 1'b0, 32'h0);

        for (int i = 0; i < 10; i++) begin
            set_sel(1'($urandom_range(0, 1)));
            tx = $urandom; sw = $urandom; ta = $urandom;
            run_frame(tx, sw, 1'($urandom_range(0, 1)),
                      ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, cd * (2 * dw + 1) - 3)) : -1,
                      1'b0, ta);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
